// File: rtl/fetch_exec_ctrl_pkg.sv
// fetch_exec_pkg: shared types and constants for the fetch/execute sequencer.
//   state_e  - sequencer states
//   cls_e    - instruction class taken from opcode bits [7:6]
//   field positions of the opcode byte and literal in the 16-bit instruction word
package fetch_exec_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_HALT,
        ST_FAULT
    } state_e;

    typedef enum logic [1:0] {
        CLS_ALU = 2'b00,
        CLS_JMP = 2'b01,
        CLS_SKZ = 2'b10,
        CLS_SYS = 2'b11
    } cls_e;

    // SYS-class sub-code that stops the machine; every other SYS code is a NOP
    localparam logic [5:0] HALT_CODE = 6'h3F;

    // Instruction word layout
    localparam int OP_HI  = 15;
    localparam int OP_LO  = 8;
    localparam int LIT_HI = 7;
    localparam int LIT_LO = 0;

    // Class field within the opcode byte
    localparam int CLS_HI = 7;
    localparam int CLS_LO = 6;

    function automatic cls_e op_class(input logic [7:0] op);
        return cls_e'(op[CLS_HI:CLS_LO]);
    endfunction

endpackage

// File: rtl/fetch_exec_ctrl_watchdog.sv
// fetch_watchdog: cycle counter guarding an outstanding fetch.
//   clk, reset : clock, async active-high reset
//   clr        : return count to zero (has priority over en)
//   en         : count this cycle
//   expire     : this enabled cycle is the TIMEOUT-th one since the last clear
module fetch_watchdog #(
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expire
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (en)
            count <= count + CNT_W'(1);
    end

    // count holds the number of earlier waiting cycles, so the current
    // cycle is number count+1
    assign expire = en && (count == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/fetch_exec_ctrl.sv
// fetch_exec_ctrl: multi-cycle fetch/decode/execute sequencer for the 8-bit
// accumulator datapath.
//   clk, reset            : clock, async active-high reset
//   start                 : (re)start at pc 0 from IDLE/HALT/FAULT
//   imem_req/addr/ack/rdata : instruction fetch handshake, addr == pc
//   w                     : accumulator value, used by skip-if-zero
//   inst_reg, b           : opcode byte to decode, literal to ALU b input
//   w_en                  : one-cycle accumulator write strobe (EXEC)
//   pc                    : program counter
//   busy, halted, fault   : status decoded from state
module fetch_exec_ctrl
    import fetch_exec_pkg::*;
#(
    parameter int PC_W    = 17,
    parameter int TIMEOUT = 15
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [15:0]     imem_rdata,
    input  logic [7:0]      w,
    output logic [7:0]      inst_reg,
    output logic [7:0]      b,
    output logic            w_en,
    output logic [PC_W-1:0] pc,
    output logic            busy,
    output logic            halted,
    output logic            fault
);

    state_e          state, state_nxt;
    logic [PC_W-1:0] pc_nxt;
    logic [7:0]      ir_nxt, b_nxt;
    logic            wd_expire;

    // Counts only fetch cycles that are still waiting; any ack or leaving
    // FETCH clears it, so each fetch gets a fresh budget.
    fetch_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
        .clk    (clk),
        .reset  (reset),
        .clr    ((state != ST_FETCH) || imem_ack),
        .en     ((state == ST_FETCH) && !imem_ack),
        .expire (wd_expire)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            pc       <= '0;
            inst_reg <= 8'h00;
            b        <= 8'h00;
        end else begin
            state    <= state_nxt;
            pc       <= pc_nxt;
            inst_reg <= ir_nxt;
            b        <= b_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        ir_nxt    = inst_reg;
        b_nxt     = b;
        case (state)
            ST_IDLE, ST_HALT, ST_FAULT: begin
                if (start) begin
                    pc_nxt    = '0;
                    state_nxt = ST_FETCH;
                end
            end
            ST_FETCH: begin
                // ack wins over a watchdog expiring in the same cycle
                if (imem_ack) begin
                    ir_nxt    = imem_rdata[OP_HI:OP_LO];
                    b_nxt     = imem_rdata[LIT_HI:LIT_LO];
                    state_nxt = ST_DECODE;
                end else if (wd_expire) begin
                    state_nxt = ST_FAULT;
                end
            end
            ST_DECODE: begin
                case (op_class(inst_reg))
                    CLS_ALU: state_nxt = ST_EXEC;
                    CLS_JMP: begin
                        pc_nxt    = PC_W'(b);
                        state_nxt = ST_FETCH;
                    end
                    CLS_SKZ: begin
                        pc_nxt    = (w == 8'h00) ? pc + PC_W'(2) : pc + PC_W'(1);
                        state_nxt = ST_FETCH;
                    end
                    default: begin
                        if (inst_reg[5:0] == HALT_CODE) begin
                            state_nxt = ST_HALT;
                        end else begin
                            pc_nxt    = pc + PC_W'(1);
                            state_nxt = ST_FETCH;
                        end
                    end
                endcase
            end
            ST_EXEC: begin
                pc_nxt    = pc + PC_W'(1);
                state_nxt = ST_FETCH;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign imem_req  = (state == ST_FETCH);
    assign imem_addr = pc;
    assign w_en      = (state == ST_EXEC);
    assign busy      = (state == ST_FETCH) || (state == ST_DECODE) || (state == ST_EXEC);
    assign halted    = (state == ST_HALT);
    assign fault     = (state == ST_FAULT);

endmodule

// File: tb/tb_fetch_exec_ctrl.sv
// Directed bench for fetch_exec_ctrl: a 17-bit-pc instance with a configurable
// wait-state memory, and a 4-bit-pc instance for wrap-around cases.
module tb_fetch_exec_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // main instance
    logic        reset = 1'b1, start = 1'b0;
    logic        imem_req, imem_ack, w_en, busy, halted, fault;
    logic [16:0] imem_addr, pc;
    logic [15:0] imem_rdata;
    logic [7:0]  w, inst_reg, b;

    logic [15:0] mem [0:255];
    int          wait_n = 0;
    logic        ack_en = 1'b1;
    logic [7:0]  wcnt = 8'd0;

    // ack after wait_n waiting cycles
    assign imem_ack   = imem_req && ack_en && (wcnt == wait_n[7:0]);
    assign imem_rdata = mem[imem_addr[7:0]];
    always @(posedge clk) wcnt <= (imem_req && !imem_ack) ? wcnt + 8'd1 : 8'd0;

    fetch_exec_ctrl #(.PC_W(17), .TIMEOUT(15)) u_dut (
        .clk(clk), .reset(reset), .start(start),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .w(w), .inst_reg(inst_reg), .b(b),
        .w_en(w_en), .pc(pc), .busy(busy), .halted(halted), .fault(fault)
    );

    // small instance, zero-wait memory
    logic        rst4 = 1'b1, start4 = 1'b0;
    logic        req4, ack4, wen4, busy4, halted4, fault4;
    logic [3:0]  addr4, pc4;
    logic [15:0] rdata4;
    logic [7:0]  w4, ir4, b4;
    logic [15:0] mem4 [0:15];

    assign ack4   = req4;
    assign rdata4 = mem4[addr4];

    fetch_exec_ctrl #(.PC_W(4), .TIMEOUT(3)) u_dut4 (
        .clk(clk), .reset(rst4), .start(start4),
        .imem_req(req4), .imem_addr(addr4), .imem_ack(ack4),
        .imem_rdata(rdata4), .w(w4), .inst_reg(ir4), .b(b4),
        .w_en(wen4), .pc(pc4), .busy(busy4), .halted(halted4), .fault(fault4)
    );

    // monitors
    int          cyc = 0, ack_cyc = 0, wen_cnt = 0, wen_gap = 0, wen4_cnt = 0;
    logic [16:0] fa_q [$];
    logic [3:0]  fa4_q [$];

    always @(posedge clk) begin
        cyc++;
        if (imem_req && imem_ack) begin
            ack_cyc = cyc;
            fa_q.push_back(imem_addr);
        end
        if (w_en) begin
            wen_cnt++;
            wen_gap = cyc - ack_cyc;
        end
        if (req4 && ack4) fa4_q.push_back(addr4);
        if (wen4) wen4_cnt++;
    end

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        fa_q.delete();
        wen_cnt = 0;
        wen_gap = 0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_to_stop(input string tag);
        for (int i = 0; i < 300 && !halted && !fault; i++) @(negedge clk);
        chk(tag, {31'd0, halted | fault}, 32'd1);
    endtask

    initial begin
        int n;
        logic stable;
        for (int i = 0; i < 256; i++) mem[i] = 16'hFF00;
        for (int i = 0; i < 16; i++) mem4[i] = 16'hFF00;
        w  = 8'h00;
        w4 = 8'h00;
        repeat (2) @(negedge clk);

        // reset state
        chk("rst_pc", pc, 0);
        chk("rst_ir", inst_reg, 0);
        chk("rst_b", b, 0);
        chk("rst_req", imem_req, 0);
        chk("rst_busy", busy, 0);
        chk("rst_halted", halted, 0);
        chk("rst_fault", fault, 0);
        chk("rst_wen", w_en, 0);
        reset = 1'b0;
        rst4  = 1'b0;
        @(negedge clk);

        // zero-wait ALU then HALT
        mem[0] = 16'h1D0A;
        mem[1] = 16'hFF00;
        clear_mon();
        pulse_start();
        chk("t1_req", imem_req, 1);
        chk("t1_addr", imem_addr, 0);
        @(negedge clk);
        chk("t1_ir", inst_reg, 8'h1D);
        chk("t1_b", b, 8'h0A);
        run_to_stop("t1_stop");
        chk("t1_halted", halted, 1);
        chk("t1_pc", pc, 1);
        chk("t1_wen_cnt", wen_cnt, 1);
        chk("t1_wen_gap", wen_gap, 2);

        // three wait states on every fetch
        wait_n = 3;
        clear_mon();
        pulse_start();
        n = 0;
        stable = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (imem_req && imem_addr == 17'd1) break;
            if (imem_req && imem_addr != 17'd0) stable = 1'b0;
            n++;
            @(negedge clk);
        end
        chk("t2_period", n, 6);
        chk("t2_addr_stable", {31'd0, stable}, 1);
        run_to_stop("t2_stop");
        chk("t2_wen_cnt", wen_cnt, 1);

        // jump
        wait_n = 0;
        mem[0] = 16'h4005;
        mem[5] = 16'hFF00;
        clear_mon();
        pulse_start();
        run_to_stop("t3_stop");
        chk("t3_nfetch", fa_q.size(), 2);
        chk("t3_target", fa_q[1], 5);
        chk("t3_pc", pc, 5);
        chk("t3_wen_cnt", wen_cnt, 0);

        // skip-if-zero at pc 2
        mem[0] = 16'h4002;
        mem[2] = 16'h8000;
        mem[3] = 16'hFF00;
        mem[4] = 16'hFF00;
        w = 8'h00;
        clear_mon();
        pulse_start();
        run_to_stop("t4a_stop");
        chk("t4a_skip_addr", fa_q[2], 4);
        chk("t4a_pc", pc, 4);
        w = 8'h07;
        clear_mon();
        pulse_start();
        run_to_stop("t4b_stop");
        chk("t4b_noskip_addr", fa_q[2], 3);
        chk("t4b_pc", pc, 3);

        // 4-bit pc: ALU at 15 wraps to 0
        mem4[0]  = 16'h400F;
        mem4[15] = 16'h0000;
        fa4_q.delete();
        wen4_cnt = 0;
        start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        repeat (6) @(negedge clk);
        chk("t5a_nfetch", {31'd0, fa4_q.size() >= 3}, 1);
        chk("t5a_jmp15", fa4_q[1], 15);
        chk("t5a_wrap", fa4_q[2], 0);
        chk("t5a_wen", wen4_cnt, 1);
        rst4 = 1'b1;
        @(negedge clk);
        rst4 = 1'b0;

        // 4-bit pc: SKZ at 14 with w=0 lands on 0
        mem4[0]  = 16'h400E;
        mem4[14] = 16'h8000;
        w4 = 8'h00;
        fa4_q.delete();
        start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        repeat (6) @(negedge clk);
        chk("t5b_jmp14", fa4_q[1], 14);
        chk("t5b_wrap2", fa4_q[2], 0);
        rst4 = 1'b1;
        @(negedge clk);
        rst4 = 1'b0;

        // watchdog: never ack
        mem[0] = 16'hFF00;
        ack_en = 1'b0;
        clear_mon();
        pulse_start();
        n = 0;
        for (int i = 0; i < 40 && !fault; i++) begin
            if (imem_req) n++;
            @(negedge clk);
        end
        chk("t6_fetch_cycles", n, 15);
        chk("t6_fault", fault, 1);
        chk("t6_req", imem_req, 0);
        chk("t6_busy", busy, 0);
        ack_en = 1'b1;
        pulse_start();
        chk("t6_restart_fault", fault, 0);
        chk("t6_restart_addr", imem_addr, 0);
        run_to_stop("t6_stop");
        chk("t6_restart_halted", halted, 1);

        // ack in the 15th fetch cycle wins
        wait_n = 14;
        clear_mon();
        pulse_start();
        run_to_stop("t7_stop");
        chk("t7_fault", fault, 0);
        chk("t7_halted", halted, 1);
        chk("t7_nfetch", fa_q.size(), 1);

        // reset in the middle of a waiting fetch
        mem[0] = 16'h1D0A;
        wait_n = 5;
        clear_mon();
        pulse_start();
        @(negedge clk);
        chk("t8_busy_before", busy, 1);
        reset = 1'b1;
        #1;
        chk("t8_req", imem_req, 0);
        chk("t8_busy", busy, 0);
        chk("t8_wen", w_en, 0);
        chk("t8_pc", pc, 0);
        chk("t8_ir", inst_reg, 0);
        chk("t8_b", b, 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        chk("t8_wen_after", wen_cnt, 0);
        chk("t8_idle", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
